// File: rtl/uc_jogo_pkg.sv
// Shared types and constants for the game control units: state encodings,
// default slot counts and index-width helper.
package uc_jogo_pkg;

  localparam int N_TIROS_PADRAO      = 8;
  localparam int N_ASTEROIDES_PADRAO = 16;

  typedef enum logic [4:0] {
    OCIOSO          = 5'b00000,
    MOVE_TIROS      = 5'b00001,
    MOVE_ASTEROIDES = 5'b00010,
    VERIFICA_NAVE   = 5'b00011,
    COLISOES        = 5'b00100,
    FIM             = 5'b00101
  } estado_t;

  localparam logic [4:0] DB_ILEGAL = 5'b11111;

  function automatic int largura_indice(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uc_coordena_asteroides_tiros_contador_indice.sv
// Modulo-N slot index counter: synchronous clear (wins over enable), enable,
// combinational ultimo flag when the count sits at N-1.
module contador_indice
  import uc_jogo_pkg::*;
#(
  parameter int N = 8,
  parameter int W = largura_indice(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  output logic [W-1:0] valor,
  output logic         ultimo
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  assign ultimo = (valor_q == W'(N - 1));
  assign valor  = valor_q;

  always_comb begin
    valor_d = valor_q;
    if (limpa) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = ultimo ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

endmodule

// File: rtl/uc_coordena_asteroides_tiros.sv
// Round sequencer for shot/asteroid movement, ship hits and shot/asteroid
// collisions; strobes are state-gated views of the same-cycle datapath flags.
module uc_coordena_asteroides_tiros
  import uc_jogo_pkg::*;
#(
  parameter int N_TIROS      = N_TIROS_PADRAO,
  parameter int N_ASTEROIDES = N_ASTEROIDES_PADRAO,
  parameter int WT           = largura_indice(N_TIROS),
  parameter int WA           = largura_indice(N_ASTEROIDES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          tiro_ativo,
  input  logic          asteroide_ativo,
  input  logic          colisao_nave,
  input  logic          colisao_tiro_asteroide,
  output logic [WT-1:0] indice_tiro,
  output logic [WA-1:0] indice_asteroide,
  output logic          move_tiro,
  output logic          move_asteroide,
  output logic          destroi_tiro,
  output logic          destroi_asteroide,
  output logic          decrementa_vida,
  output logic          ocupado,
  output logic          fim_movimentacao,
  output logic [4:0]    db_estado
);

  estado_t estado_q;
  estado_t estado_d;

  logic limpa_t, conta_t, ultimo_t;
  logic limpa_a, conta_a, ultimo_a;

  contador_indice #(.N(N_TIROS), .W(WT)) u_cont_tiro (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa_t),
    .conta  (conta_t),
    .valor  (indice_tiro),
    .ultimo (ultimo_t)
  );

  contador_indice #(.N(N_ASTEROIDES), .W(WA)) u_cont_asteroide (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa_a),
    .conta  (conta_a),
    .valor  (indice_asteroide),
    .ultimo (ultimo_a)
  );

  assign ocupado = (estado_q != OCIOSO);

  always_comb begin
    estado_d          = estado_q;
    limpa_t           = 1'b0;
    conta_t           = 1'b0;
    limpa_a           = 1'b0;
    conta_a           = 1'b0;
    move_tiro         = 1'b0;
    move_asteroide    = 1'b0;
    destroi_tiro      = 1'b0;
    destroi_asteroide = 1'b0;
    decrementa_vida   = 1'b0;
    fim_movimentacao  = 1'b0;
    db_estado         = estado_q;
    case (estado_q)
      OCIOSO: begin
        limpa_t = 1'b1;
        limpa_a = 1'b1;
        if (iniciar) estado_d = MOVE_TIROS;
      end
      MOVE_TIROS: begin
        move_tiro = tiro_ativo;
        conta_t   = 1'b1;
        if (ultimo_t) estado_d = MOVE_ASTEROIDES;
      end
      MOVE_ASTEROIDES: begin
        move_asteroide = asteroide_ativo;
        conta_a        = 1'b1;
        if (ultimo_a) estado_d = VERIFICA_NAVE;
      end
      VERIFICA_NAVE: begin
        if (asteroide_ativo && colisao_nave) begin
          decrementa_vida   = 1'b1;
          destroi_asteroide = 1'b1;
        end
        conta_a = 1'b1;
        if (ultimo_a) begin
          limpa_t  = 1'b1;
          estado_d = COLISOES;
        end
      end
      COLISOES: begin
        // An inactive shot or a kill ends the row at once: one kill per shot.
        if (!tiro_ativo) begin
          conta_t = 1'b1;
          limpa_a = 1'b1;
          if (ultimo_t) estado_d = FIM;
        end else if (asteroide_ativo && colisao_tiro_asteroide) begin
          destroi_tiro      = 1'b1;
          destroi_asteroide = 1'b1;
          conta_t           = 1'b1;
          limpa_a           = 1'b1;
          if (ultimo_t) estado_d = FIM;
        end else begin
          conta_a = 1'b1;
          if (ultimo_a) begin
            conta_t = 1'b1;
            if (ultimo_t) estado_d = FIM;
          end
        end
      end
      FIM: begin
        fim_movimentacao = 1'b1;
        limpa_t          = 1'b1;
        limpa_a          = 1'b1;
        estado_d         = OCIOSO;
      end
      default: begin
        db_estado = DB_ILEGAL;
        limpa_t   = 1'b1;
        limpa_a   = 1'b1;
        estado_d  = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

endmodule

// File: tb/tb_uc_coordena_asteroides_tiros.sv
// Directed bench: a static slot model feeds the datapath flags back from the indices.
module tb_uc_coordena_asteroides_tiros;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic        tiro_ativo, asteroide_ativo, colisao_nave, colisao_tiro_asteroide;
  logic [2:0]  indice_tiro;
  logic [3:0]  indice_asteroide;
  logic        move_tiro, move_asteroide, destroi_tiro, destroi_asteroide;
  logic        decrementa_vida, ocupado, fim_movimentacao;
  logic [4:0]  db_estado;

  logic [7:0]        tiro_act;
  logic [15:0]       ast_act;
  logic [15:0]       nave_col;
  logic [7:0][15:0]  ta_col;

  int checks = 0;
  int failures = 0;

  int          n_mt, n_ma, n_dt, n_da, n_dv, n_fim, fim_cycle, post_hit_i;
  logic [7:0]  mask_mt;
  logic [15:0] mask_ma, mask_da;
  int          dv_idx, dt_i, dt_j;
  logic        ocup_first, hit_prev;

  always #5 clock = ~clock;

  assign tiro_ativo             = tiro_act[indice_tiro];
  assign asteroide_ativo        = ast_act[indice_asteroide];
  assign colisao_nave           = nave_col[indice_asteroide];
  assign colisao_tiro_asteroide = ta_col[indice_tiro][indice_asteroide];

  uc_coordena_asteroides_tiros dut (
    .clock                  (clock),
    .reset                  (reset),
    .iniciar                (iniciar),
    .tiro_ativo             (tiro_ativo),
    .asteroide_ativo        (asteroide_ativo),
    .colisao_nave           (colisao_nave),
    .colisao_tiro_asteroide (colisao_tiro_asteroide),
    .indice_tiro            (indice_tiro),
    .indice_asteroide       (indice_asteroide),
    .move_tiro              (move_tiro),
    .move_asteroide         (move_asteroide),
    .destroi_tiro           (destroi_tiro),
    .destroi_asteroide      (destroi_asteroide),
    .decrementa_vida        (decrementa_vida),
    .ocupado                (ocupado),
    .fim_movimentacao       (fim_movimentacao),
    .db_estado              (db_estado)
  );

  task automatic clear_model();
    tiro_act = '0;
    ast_act  = '0;
    nave_col = '0;
    ta_col   = '0;
  endtask

  // Pulse iniciar, then log strobes once per cycle until fim or the budget runs out.
  task automatic run_round(input int max_cyc);
    n_mt = 0; n_ma = 0; n_dt = 0; n_da = 0; n_dv = 0; n_fim = 0;
    fim_cycle = -1; post_hit_i = -1; mask_mt = '0; mask_ma = '0; mask_da = '0;
    dv_idx = -1; dt_i = -1; dt_j = -1; hit_prev = 1'b0;
    @(negedge clock);
    iniciar = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock);
      if (c == 1) begin
        ocup_first = ocupado;
        iniciar    = 1'b0;
      end
      if (hit_prev) begin
        post_hit_i = int'(indice_tiro);
        hit_prev   = 1'b0;
      end
      if (move_tiro) begin n_mt++; mask_mt[indice_tiro] = 1'b1; end
      if (move_asteroide) begin n_ma++; mask_ma[indice_asteroide] = 1'b1; end
      if (decrementa_vida) begin n_dv++; dv_idx = int'(indice_asteroide); end
      if (destroi_asteroide) begin n_da++; mask_da[indice_asteroide] = 1'b1; end
      if (destroi_tiro) begin
        n_dt++;
        dt_i = int'(indice_tiro);
        dt_j = int'(indice_asteroide);
        hit_prev = 1'b1;
      end
      if (fim_movimentacao) begin
        n_fim++;
        fim_cycle = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; clear_model();
    repeat (2) @(negedge clock);
    checks++;
    if (db_estado !== 5'b00000) begin failures++; $display("FAIL reset_state got=%b exp=00000", db_estado); end
    checks++;
    if (indice_tiro !== 3'd0 || indice_asteroide !== 4'd0) begin
      failures++; $display("FAIL reset_idx got=%0d,%0d exp=0,0", indice_tiro, indice_asteroide);
    end
    checks++;
    if ({move_tiro, move_asteroide, destroi_tiro, destroi_asteroide, decrementa_vida, ocupado, fim_movimentacao} !== 7'b0) begin
      failures++; $display("FAIL reset_outs got=%b exp=0000000",
        {move_tiro, move_asteroide, destroi_tiro, destroi_asteroide, decrementa_vida, ocupado, fim_movimentacao});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_idle_round();
    clear_model();
    run_round(200);
    checks++;
    if (ocup_first !== 1'b1) begin failures++; $display("FAIL idle_ocupado got=%b exp=1", ocup_first); end
    checks++;
    if (fim_cycle != 49 || n_fim != 1) begin failures++; $display("FAIL idle_fim_cycle got=%0d exp=49", fim_cycle); end
    checks++;
    if (n_mt + n_ma + n_dt + n_da + n_dv != 0) begin
      failures++; $display("FAIL idle_strobes got=%0d exp=0", n_mt + n_ma + n_dt + n_da + n_dv);
    end
    @(negedge clock);
    checks++;
    if (fim_movimentacao !== 1'b0 || ocupado !== 1'b0) begin
      failures++; $display("FAIL idle_after_fim got=fim%b,ocup%b exp=0,0", fim_movimentacao, ocupado);
    end
  endtask

  task automatic test_moves();
    clear_model();
    tiro_act[0] = 1'b1; tiro_act[3] = 1'b1; ast_act[5] = 1'b1;
    run_round(300);
    checks++;
    if (n_mt != 2 || mask_mt !== 8'b0000_1001) begin failures++; $display("FAIL move_tiro got=%0d/%b exp=2/00001001", n_mt, mask_mt); end
    checks++;
    if (n_ma != 1 || mask_ma !== 16'h0020) begin failures++; $display("FAIL move_ast got=%0d/%h exp=1/0020", n_ma, mask_ma); end
    checks++;
    if (fim_cycle != 79) begin failures++; $display("FAIL move_fim_cycle got=%0d exp=79", fim_cycle); end
    checks++;
    if (n_dt + n_da + n_dv != 0) begin failures++; $display("FAIL move_destroys got=%0d exp=0", n_dt + n_da + n_dv); end
  endtask

  task automatic test_nave();
    clear_model();
    ast_act[7] = 1'b1; nave_col[7] = 1'b1; nave_col[2] = 1'b1;
    run_round(200);
    checks++;
    if (n_dv != 1 || dv_idx != 7) begin failures++; $display("FAIL nave_vida got=%0d@%0d exp=1@7", n_dv, dv_idx); end
    checks++;
    if (n_da != 1 || mask_da !== 16'h0080) begin failures++; $display("FAIL nave_destroi got=%0d/%h exp=1/0080", n_da, mask_da); end
    checks++;
    if (n_dt != 0 || fim_cycle != 49) begin failures++; $display("FAIL nave_misc got=dt%0d,fim%0d exp=dt0,fim49", n_dt, fim_cycle); end
  endtask

  task automatic test_colisao();
    clear_model();
    tiro_act[2] = 1'b1; ast_act[4] = 1'b1; ast_act[9] = 1'b1;
    ta_col[2][4] = 1'b1; ta_col[2][9] = 1'b1;
    run_round(300);
    checks++;
    if (n_dt != 1 || dt_i != 2 || dt_j != 4) begin failures++; $display("FAIL col_pair got=%0d@(%0d,%0d) exp=1@(2,4)", n_dt, dt_i, dt_j); end
    checks++;
    if (n_da != 1 || mask_da !== 16'h0010) begin failures++; $display("FAIL col_ast got=%0d/%h exp=1/0010", n_da, mask_da); end
    checks++;
    if (post_hit_i != 3) begin failures++; $display("FAIL col_next_i got=%0d exp=3", post_hit_i); end
    checks++;
    if (fim_cycle != 53 || mask_ma !== 16'h0210) begin failures++; $display("FAIL col_round got=fim%0d,ma%h exp=fim53,ma0210", fim_cycle, mask_ma); end
  endtask

  task automatic test_abort();
    int  budget;
    int  bad;
    clear_model();
    tiro_act[1] = 1'b1; tiro_act[5] = 1'b1;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    budget = 0;
    while (db_estado !== 5'b00100 && budget < 100) begin @(negedge clock); budget++; end
    checks++;
    if (budget >= 100) begin failures++; $display("FAIL abort_reach_colisoes got=%b exp=00100", db_estado); end
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    budget = 0;
    while (indice_tiro !== 3'd5 && budget < 100) begin @(negedge clock); budget++; end
    checks++;
    if (budget >= 100 || db_estado !== 5'b00100) begin
      failures++; $display("FAIL abort_at_i5 got=i%0d,st%b exp=i5,st00100", indice_tiro, db_estado);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 5'b00000 || indice_tiro !== 3'd0 || indice_asteroide !== 4'd0 ||
        {move_tiro, move_asteroide, destroi_tiro, destroi_asteroide, decrementa_vida, fim_movimentacao} !== 6'b0) begin
      failures++; $display("FAIL abort_reset got=st%b,i%0d,j%0d exp=st00000,i0,j0", db_estado, indice_tiro, indice_asteroide);
    end
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (fim_movimentacao || ocupado) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abort_no_round got=%0d exp=0", bad); end
  endtask

  task automatic test_illegal();
    clear_model();
    @(negedge clock);
    force dut.estado_q = uc_jogo_pkg::estado_t'(5'b11111);
    #1;
    checks++;
    if (db_estado !== 5'b11111 || ocupado !== 1'b1) begin
      failures++; $display("FAIL illegal_db got=%b,ocup%b exp=11111,1", db_estado, ocupado);
    end
    release dut.estado_q;
    @(negedge clock);
    checks++;
    if (db_estado !== 5'b00000 || ocupado !== 1'b0) begin
      failures++; $display("FAIL illegal_recover got=%b exp=00000", db_estado);
    end
  endtask

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    clear_model();
    test_reset();
    test_idle_round();
    test_moves();
    test_nave();
    test_colisao();
    test_abort();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
